teclado_cajero: RTL and testbench

- Keypad front-end that sits directly upstream of the ATM controller. It produces that controller's DIGITO/DIGITO_STB and MONTO/MONTO_STB inputs.
- Synchronises and debounces a raw mechanical keypad, then emits one action per physical press.
- In PIN mode it forwards single digits. In amount mode it accumulates decimal digits into a 32-bit binary MONTO, committed on ENTER.

---
 rtl/teclado_cajero_if.sv | 24 ++
 rtl/teclado_cajero.sv | 190 +++++++++++++++++++
 tb/tb_teclado_cajero.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/teclado_cajero_if.sv
// Keypad-side bundle: raw key inputs toward the front-end, digit/amount results toward the ATM controller.
// Combinational only; no latency of its own.
// No backpressure: the strobes are single-cycle pulses the consumer must take as they come.
interface teclado_cajero_if;
    logic        TECLA_ACTIVA;
    logic [3:0]  TECLA;
    logic        MODO_MONTO;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic [3:0]  CANT_DIGITOS;
    logic        TECLA_INVALIDA;

    modport master (
        output TECLA_ACTIVA, TECLA, MODO_MONTO,
        input  DIGITO, DIGITO_STB, MONTO, MONTO_STB, CANT_DIGITOS, TECLA_INVALIDA
    );

    modport slave (
        input  TECLA_ACTIVA, TECLA, MODO_MONTO,
        output DIGITO, DIGITO_STB, MONTO, MONTO_STB, CANT_DIGITOS, TECLA_INVALIDA
    );
endinterface

// File: rtl/teclado_cajero.sv
// Debounced keypad front-end: one PIN digit or amount-accumulator action per physical press.
// Latency: strobe 2 (sync) + DEBOUNCE_CICLOS + 1 edges after a clean key-down.
// No backpressure: holding a key never repeats; strobes are one-cycle pulses.
module teclado_cajero #(
    parameter int DEBOUNCE_CICLOS = 16,
    parameter int MAX_DIGITOS     = 9
) (
    input  logic           clk,
    input  logic           rst,
    teclado_cajero_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] CNT_UNO = CW'(1);
    localparam logic [CW-1:0] CNT_FIN = CW'(DEBOUNCE_CICLOS);
    localparam logic [3:0]    MAX_D   = 4'(MAX_DIGITOS);
    localparam logic [3:0]    K_ENTER = 4'hA;
    localparam logic [3:0]    K_CLEAR = 4'hB;

    typedef enum logic [2:0] {
        REPOSO, ANTIRREBOTE_P, ACCION, ESPERA_SOLTAR, ANTIRREBOTE_S
    } estado_t;

    estado_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          latch;

    logic          act_m, act_s;
    logic [3:0]    tecla_m, tecla_s;
    logic          modo_prev;
    logic [3:0]    tecla_l;
    logic          modo_l;
    logic          es_dig;

    logic [3:0]    digito_q, digito_d;
    logic [31:0]   monto_q, monto_d;
    logic [31:0]   acc_q, acc_d;
    logic [3:0]    cant_q, cant_d;
    logic          dstb_q, dstb_d;
    logic          mstb_q, mstb_d;
    logic          inv_q, inv_d;

    // Two-flop synchronisers; the mode input is only edge-compared, not synchronised.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_m     <= 1'b0;
            act_s     <= 1'b0;
            tecla_m   <= 4'd0;
            tecla_s   <= 4'd0;
            modo_prev <= 1'b0;
        end else begin
            act_m     <= bus.TECLA_ACTIVA;
            act_s     <= act_m;
            tecla_m   <= bus.TECLA;
            tecla_s   <= tecla_m;
            modo_prev <= bus.MODO_MONTO;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= REPOSO;
            cnt_q   <= '0;
            tecla_l <= 4'd0;
            modo_l  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                tecla_l <= tecla_s;
                modo_l  <= bus.MODO_MONTO;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        case (state_q)
            REPOSO: begin
                if (act_s) begin
                    state_d = ANTIRREBOTE_P;
                    cnt_d   = CNT_UNO;
                end
            end
            ANTIRREBOTE_P: begin
                cnt_d = cnt_q + CNT_UNO;
                if (!act_s) begin
                    state_d = REPOSO;
                end else if (cnt_q + CNT_UNO == CNT_FIN) begin
                    state_d = ACCION;
                    latch   = 1'b1;
                end
            end
            ACCION: state_d = ESPERA_SOLTAR;
            ESPERA_SOLTAR: begin
                if (!act_s) begin
                    state_d = ANTIRREBOTE_S;
                    cnt_d   = CNT_UNO;
                end
            end
            ANTIRREBOTE_S: begin
                cnt_d = cnt_q + CNT_UNO;
                if (act_s) begin
                    state_d = ESPERA_SOLTAR;
                end else if (cnt_q + CNT_UNO == CNT_FIN) begin
                    state_d = REPOSO;
                end
            end
            default: state_d = REPOSO;
        endcase
    end

    assign es_dig = (tecla_l <= 4'd9);

    always_comb begin
        digito_d = digito_q;
        monto_d  = monto_q;
        acc_d    = acc_q;
        cant_d   = cant_q;
        dstb_d   = 1'b0;
        mstb_d   = 1'b0;
        inv_d    = 1'b0;
        if (bus.MODO_MONTO != modo_prev) begin
            acc_d  = 32'd0;
            cant_d = 4'd0;
        end
        // The latched action wins over a simultaneous mode-change clear.
        if (state_q == ACCION) begin
            if (!modo_l) begin
                if (es_dig) begin
                    digito_d = tecla_l;
                    dstb_d   = 1'b1;
                end else begin
                    inv_d = 1'b1;
                end
            end else if (es_dig) begin
                if (cant_q < MAX_D) begin
                    acc_d    = acc_q * 32'd10 + {28'd0, tecla_l};
                    cant_d   = cant_q + 4'd1;
                    digito_d = tecla_l;
                    dstb_d   = 1'b1;
                end else begin
                    inv_d = 1'b1;
                end
            end else if (tecla_l == K_ENTER) begin
                if (cant_q != 4'd0) begin
                    monto_d = acc_q;
                    mstb_d  = 1'b1;
                    acc_d   = 32'd0;
                    cant_d  = 4'd0;
                end else begin
                    inv_d = 1'b1;
                end
            end else if (tecla_l == K_CLEAR) begin
                acc_d  = 32'd0;
                cant_d = 4'd0;
            end else begin
                inv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digito_q <= 4'd0;
            monto_q  <= 32'd0;
            acc_q    <= 32'd0;
            cant_q   <= 4'd0;
            dstb_q   <= 1'b0;
            mstb_q   <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            digito_q <= digito_d;
            monto_q  <= monto_d;
            acc_q    <= acc_d;
            cant_q   <= cant_d;
            dstb_q   <= dstb_d;
            mstb_q   <= mstb_d;
            inv_q    <= inv_d;
        end
    end

    assign bus.DIGITO         = digito_q;
    assign bus.DIGITO_STB     = dstb_q;
    assign bus.MONTO          = monto_q;
    assign bus.MONTO_STB      = mstb_q;
    assign bus.CANT_DIGITOS   = cant_q;
    assign bus.TECLA_INVALIDA = inv_q;
endmodule

// File: tb/tb_teclado_cajero.sv
// Bench for teclado_cajero: directed scenarios plus random key presses, each press scored against a
// transaction-level model of the keypad rules (integer accumulator, digit count, last amount).
module tb_teclado_cajero;
    logic clk;
    logic rst;
    teclado_cajero_if ifc ();

    teclado_cajero #(.DEBOUNCE_CICLOS(4), .MAX_DIGITOS(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    localparam int LAT = 2 + 4 + 1;

    typedef struct {
        int          kind;
        logic [3:0]  dig;
        logic [31:0] mon;
        int          cyc;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;

    longint      m_acc;
    int          m_cnt;
    logic [31:0] m_monto;
    logic [3:0]  m_digito;
    logic        cur_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int  nstb;
        ev_t e;
        nstb = int'(ifc.DIGITO_STB) + int'(ifc.MONTO_STB) + int'(ifc.TECLA_INVALIDA);
        if (nstb != 0) begin
            chk("stb_onehot", nstb, 1);
            e.kind = ifc.DIGITO_STB ? 1 : (ifc.MONTO_STB ? 2 : 3);
            e.dig  = ifc.DIGITO;
            e.mon  = ifc.MONTO;
            e.cyc  = cyc;
            evq.push_back(e);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected result of one accepted press: 0 none, 1 digit, 2 amount, 3 rejected.
    task automatic model_press(input logic mode, input logic [3:0] key, output int kind);
        kind = 0;
        if (!mode) begin
            if (key <= 4'd9) begin
                m_digito = key;
                kind = 1;
            end else kind = 3;
        end else if (key <= 4'd9) begin
            if (m_cnt < 9) begin
                m_acc = m_acc * 10 + longint'(key);
                m_cnt++;
                m_digito = key;
                kind = 1;
            end else kind = 3;
        end else if (key == 4'hA) begin
            if (m_cnt > 0) begin
                m_monto = m_acc[31:0];
                m_acc = 0;
                m_cnt = 0;
                kind = 2;
            end else kind = 3;
        end else if (key == 4'hB) begin
            m_acc = 0;
            m_cnt = 0;
        end else kind = 3;
    endtask

    task automatic set_mode(input logic m);
        if (m != cur_mode) begin
            m_acc = 0;
            m_cnt = 0;
        end
        cur_mode = m;
        ifc.MODO_MONTO = m;
        wait_cyc(4);
        chk("mode_cant", ifc.CANT_DIGITOS, m_cnt);
    endtask

    task automatic press(input logic [3:0] key, input bit bouncy, input int hold);
        int  kind;
        int  rise;
        int  n;
        ev_t e;
        ifc.TECLA = key;
        wait_cyc(3);
        if (bouncy) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                ifc.TECLA_ACTIVA = 1'b1;
                wait_cyc($urandom_range(1, 3));
                ifc.TECLA_ACTIVA = 1'b0;
                wait_cyc($urandom_range(1, 3));
            end
        end
        ifc.TECLA_ACTIVA = 1'b1;
        rise = cyc;
        wait_cyc(9);
        ifc.TECLA = 4'($urandom);
        wait_cyc(hold - 9);
        if (bouncy) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                ifc.TECLA_ACTIVA = 1'b0;
                wait_cyc($urandom_range(1, 3));
                ifc.TECLA_ACTIVA = 1'b1;
                wait_cyc($urandom_range(1, 3));
            end
        end
        ifc.TECLA_ACTIVA = 1'b0;
        wait_cyc(12);
        model_press(cur_mode, key, kind);
        chk("ev_count", evq.size(), (kind != 0) ? 1 : 0);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            chk("ev_kind", e.kind, kind);
            chk("ev_latency", e.cyc - rise, LAT);
            if (kind == 1) chk("ev_digito", e.dig, key);
            if (kind == 2) chk("ev_monto", e.mon, m_monto);
        end
        evq.delete();
        chk("digito", ifc.DIGITO, m_digito);
        chk("monto", ifc.MONTO, m_monto);
        chk("cant", ifc.CANT_DIGITOS, m_cnt);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_digito"}, ifc.DIGITO, 0);
        chk({tag, "_monto"}, ifc.MONTO, 0);
        chk({tag, "_cant"}, ifc.CANT_DIGITOS, 0);
        chk({tag, "_stbs"}, {29'd0, ifc.DIGITO_STB, ifc.MONTO_STB, ifc.TECLA_INVALIDA}, 0);
    endtask

    initial begin
        int r;
        rst = 1'b0;
        ifc.TECLA_ACTIVA = 1'b0;
        ifc.TECLA = 4'd0;
        ifc.MODO_MONTO = 1'b0;
        cur_mode = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        m_monto = 32'd0;
        m_digito = 4'd0;
        #23;
        chk_all_zero("reset");
        rst = 1'b1;
        wait_cyc(3);

        // PIN digit held for a long time: one strobe only
        set_mode(1'b0);
        press(4'd7, 1'b0, 100);
        chk("pin7_digito", ifc.DIGITO, 7);

        set_mode(1'b1);
        press(4'd1, 1'b0, 12);
        press(4'd2, 1'b0, 12);
        press(4'd5, 1'b0, 12);
        press(4'd0, 1'b0, 12);
        chk("cant_4", ifc.CANT_DIGITOS, 4);
        press(4'hA, 1'b0, 12);
        chk("monto_1250", ifc.MONTO, 32'h4E2);

        set_mode(1'b0);
        press(4'd3, 1'b1, 15);

        set_mode(1'b1);
        for (int i = 0; i < 10; i++) press(4'd9, 1'b0, 10);
        press(4'hA, 1'b0, 10);
        chk("monto_max", ifc.MONTO, 999999999);
        press(4'hA, 1'b0, 10);
        chk("monto_kept", ifc.MONTO, 999999999);

        press(4'd4, 1'b0, 10);
        press(4'd2, 1'b0, 10);
        press(4'hB, 1'b0, 10);
        press(4'd8, 1'b0, 10);
        press(4'hA, 1'b0, 10);
        chk("monto_8", ifc.MONTO, 8);
        set_mode(1'b0);
        press(4'hA, 1'b0, 10);

        // Asynchronous reset in the middle of press debounce with acc=42
        set_mode(1'b1);
        press(4'd4, 1'b0, 10);
        press(4'd2, 1'b0, 10);
        ifc.TECLA = 4'hA;
        wait_cyc(3);
        ifc.TECLA_ACTIVA = 1'b1;
        wait_cyc(4);
        #3;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        m_acc = 0;
        m_cnt = 0;
        m_monto = 32'd0;
        m_digito = 4'd0;
        wait_cyc(2);
        ifc.TECLA_ACTIVA = 1'b0;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(15);
        chk("rst_no_event", evq.size(), 0);
        evq.delete();
        press(4'hA, 1'b0, 10);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] key;
            if ($urandom_range(0, 7) == 0) set_mode(~cur_mode);
            r = $urandom_range(0, 99);
            if (r < 70)      key = 4'($urandom_range(0, 9));
            else if (r < 85) key = 4'hA;
            else if (r < 92) key = 4'hB;
            else             key = 4'($urandom_range(12, 15));
            press(key, 1'($urandom_range(0, 1)), $urandom_range(10, 25));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
